// File: rtl/flash_sample_streamer.sv
// Streams 8-bit samples from SPI flash through a small FIFO and releases one per sample period.
// Fetch runs ahead of playback; the flash region loops, and empty periods are counted as underruns.
module flash_sample_streamer #(
    parameter int unsigned          SAMPLE_DIV = 1200,
    parameter int unsigned          FIFO_DEPTH = 8,
    parameter int unsigned          ADDR_BITS  = 24,
    parameter logic [ADDR_BITS-1:0] START_ADDR = '0,
    parameter int unsigned          LENGTH     = 24'h100000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_enable,
    output logic                          o_spi_start_read,
    output logic                          o_spi_continue_read,
    output logic                          o_spi_stop_read,
    output logic [ADDR_BITS-1:0]          o_spi_addr,
    input  logic [7:0]                    i_spi_data,
    input  logic                          i_spi_busy,
    output logic [7:0]                    o_sample,
    output logic                          o_sample_strobe,
    output logic                          o_underrun,
    output logic [7:0]                    o_underrun_count,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int unsigned     PtrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned     LvlW    = PtrW + 1;
    localparam int unsigned     DivW    = $clog2(SAMPLE_DIV);
    localparam int unsigned     CntW    = $clog2(LENGTH + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(SAMPLE_DIV - 1);
    localparam logic [CntW-1:0] LenLast = CntW'(LENGTH - 1);
    localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitHi,
        StWaitLo,
        StHold,
        StStop
    } state_e;

    state_e            r_state;
    logic              r_first;
    logic [CntW-1:0]   r_byte_cnt;
    logic              r_start_read;
    logic              r_continue_read;
    logic              r_stop_read;

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PtrW-1:0]   r_wptr;
    logic [PtrW-1:0]   r_rptr;
    logic [LvlW-1:0]   r_level;
    logic [DivW-1:0]   r_div_cnt;
    logic [7:0]        r_sample;
    logic              r_sample_strobe;
    logic              r_underrun;
    logic [7:0]        r_underrun_count;

    logic              w_full;
    logic              w_push;
    logic              w_tc;
    logic              w_pop;
    logic              w_underrun;

    assign w_full     = (r_level == LvlFull);
    // A byte that completes after enable has dropped is discarded.
    assign w_push     = (r_state == StWaitLo) && !i_spi_busy && i_enable;
    assign w_tc       = i_enable && (r_div_cnt == DivLast);
    assign w_pop      = w_tc && (r_level != '0);
    assign w_underrun = w_tc && (r_level == '0);

    // Request pulses are registered on entry to StIssue/StStop so they are high during that state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= StIdle;
            r_first         <= 1'b0;
            r_byte_cnt      <= '0;
            r_start_read    <= 1'b0;
            r_continue_read <= 1'b0;
            r_stop_read     <= 1'b0;
        end else begin
            r_start_read    <= 1'b0;
            r_continue_read <= 1'b0;
            r_stop_read     <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_enable) begin
                        r_state      <= StIssue;
                        r_first      <= 1'b0;
                        r_byte_cnt   <= '0;
                        r_start_read <= 1'b1;
                    end
                end
                StIssue: begin
                    r_state <= StWaitHi;
                end
                StWaitHi: begin
                    if (i_spi_busy) begin
                        r_state <= StWaitLo;
                    end
                end
                StWaitLo: begin
                    if (!i_spi_busy) begin
                        r_byte_cnt <= r_byte_cnt + CntW'(1);
                        if (!i_enable || (r_byte_cnt == LenLast)) begin
                            r_state     <= StStop;
                            r_stop_read <= 1'b1;
                        end else begin
                            r_state <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (!i_enable) begin
                        r_state     <= StStop;
                        r_stop_read <= 1'b1;
                    end else if (!w_full) begin
                        r_state         <= StIssue;
                        r_start_read    <= r_first;
                        r_continue_read <= !r_first;
                        r_first         <= 1'b0;
                    end
                end
                StStop: begin
                    if (i_enable) begin
                        r_byte_cnt <= '0;
                        // A wrap that lands on a full FIFO parks in StHold until a slot frees.
                        if (w_full) begin
                            r_state <= StHold;
                            r_first <= 1'b1;
                        end else begin
                            r_state      <= StIssue;
                            r_first      <= 1'b0;
                            r_start_read <= 1'b1;
                        end
                    end else begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_spi_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr           <= '0;
            r_rptr           <= '0;
            r_level          <= '0;
            r_div_cnt        <= '0;
            r_sample         <= 8'h80;
            r_sample_strobe  <= 1'b0;
            r_underrun       <= 1'b0;
            r_underrun_count <= 8'h00;
        end else if (!i_enable) begin
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_level         <= '0;
            r_div_cnt       <= '0;
            r_sample        <= 8'h80;
            r_sample_strobe <= 1'b0;
            r_underrun      <= 1'b0;
        end else begin
            r_sample_strobe <= w_pop;
            r_underrun      <= w_underrun;
            r_div_cnt       <= w_tc ? '0 : r_div_cnt + DivW'(1);
            if (w_push) begin
                r_wptr <= r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_sample <= r_mem[r_rptr];
                r_rptr   <= r_rptr + PtrW'(1);
            end
            if (w_underrun && (r_underrun_count != 8'hFF)) begin
                r_underrun_count <= r_underrun_count + 8'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LvlW'(1);
                2'b01:   r_level <= r_level - LvlW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_spi_start_read    = r_start_read;
    assign o_spi_continue_read = r_continue_read;
    assign o_spi_stop_read     = r_stop_read;
    assign o_spi_addr          = START_ADDR;
    assign o_sample            = r_sample;
    assign o_sample_strobe     = r_sample_strobe;
    assign o_underrun          = r_underrun;
    assign o_underrun_count    = r_underrun_count;
    assign o_fifo_level        = r_level;

endmodule

// File: tb/tb_flash_sample_streamer.sv
// Scoreboard bench for flash_sample_streamer: a flash model feeds bytes and queues expected samples,
// a monitor replays the sample pacer and checks every strobe/underrun against that queue.
module tb_flash_sample_streamer;

    localparam int unsigned DIV   = 64;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LEN   = 6;
    localparam int unsigned LAT   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        spi_start_read;
    logic        spi_continue_read;
    logic        spi_stop_read;
    logic [23:0] spi_addr;
    logic [7:0]  spi_data;
    logic        spi_busy;
    logic [7:0]  sample;
    logic        sample_strobe;
    logic        underrun;
    logic [7:0]  underrun_count;
    logic [3:0]  fifo_level;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [7:0]  exp_q[$];

    int          starts    = 0;
    int          conts     = 0;
    int          stops     = 0;
    int          stall_len = 0;
    logic        pending   = 1'b0;
    logic [7:0]  pend_byte = 8'h00;

    always #5 clk = ~clk;

    flash_sample_streamer #(
        .SAMPLE_DIV (DIV),
        .FIFO_DEPTH (DEPTH),
        .ADDR_BITS  (24),
        .START_ADDR (24'h000000),
        .LENGTH     (LEN)
    ) u_dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_enable            (enable),
        .o_spi_start_read    (spi_start_read),
        .o_spi_continue_read (spi_continue_read),
        .o_spi_stop_read     (spi_stop_read),
        .o_spi_addr          (spi_addr),
        .i_spi_data          (spi_data),
        .i_spi_busy          (spi_busy),
        .o_sample            (sample),
        .o_sample_strobe     (sample_strobe),
        .o_underrun          (underrun),
        .o_underrun_count    (underrun_count),
        .o_fifo_level        (fifo_level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Flash controller model: acts at negedge+1, pushes the expected byte one cycle after busy falls.
    initial begin : flash
        int          fst;
        int          cnt;
        logic [23:0] faddr;
        fst      = 0;
        cnt      = 0;
        faddr    = '0;
        spi_busy = 1'b0;
        spi_data = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (pending) begin
                pending = 1'b0;
                if (!rst && enable) begin
                    chk("push_not_full", exp_q.size() < DEPTH, 1);
                    exp_q.push_back(pend_byte);
                end
            end
            if (spi_stop_read) stops++;
            if (rst) begin
                fst      = 0;
                spi_busy = 1'b0;
            end else begin
                case (fst)
                    0: begin
                        if (spi_start_read) begin
                            faddr = spi_addr;
                            starts++;
                            fst = 1;
                        end else if (spi_continue_read) begin
                            faddr = faddr + 24'd1;
                            conts++;
                            fst = 1;
                        end
                    end
                    1: begin
                        spi_busy  = 1'b1;
                        spi_data  = 8'h5A;
                        cnt       = (stall_len > 0) ? stall_len : LAT;
                        stall_len = 0;
                        fst       = 2;
                    end
                    default: begin
                        cnt--;
                        if (cnt == 0) begin
                            spi_busy  = 1'b0;
                            spi_data  = faddr[7:0];
                            pend_byte = faddr[7:0];
                            pending   = 1'b1;
                            fst       = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: replays the pacer and pops the expected queue on each terminal count.
    initial begin : monitor
        int         m_div;
        logic       ev;
        logic [7:0] m_last;
        logic [7:0] m_ucnt;
        logic [7:0] exp_s;
        logic       prev_start;
        logic       prev_cont;
        logic       prev_stop;
        m_div      = 0;
        m_last     = 8'h80;
        m_ucnt     = 8'h00;
        prev_start = 1'b0;
        prev_cont  = 1'b0;
        prev_stop  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete();
                m_div  = 0;
                m_last = 8'h80;
                m_ucnt = 8'h00;
            end else if (!enable) begin
                exp_q.delete();
                m_div  = 0;
                m_last = 8'h80;
                chk("idle_pulses", {sample_strobe, underrun}, 2'b00);
                chk("idle_sample", sample, 8'h80);
                chk("idle_level", fifo_level, 0);
            end else begin
                ev    = (m_div == DIV - 1);
                m_div = ev ? 0 : m_div + 1;
                if (ev && exp_q.size() > 0) begin
                    exp_s = exp_q.pop_front();
                    chk("strobe_event", {sample_strobe, underrun}, 2'b10);
                    chk("sample_value", sample, exp_s);
                    m_last = exp_s;
                end else if (ev) begin
                    if (m_ucnt != 8'hFF) m_ucnt = m_ucnt + 8'd1;
                    chk("underrun_event", {sample_strobe, underrun}, 2'b01);
                    chk("underrun_hold", sample, m_last);
                    chk("underrun_count", underrun_count, m_ucnt);
                end else begin
                    chk("no_event", {sample_strobe, underrun}, 2'b00);
                end
            end
            if (spi_start_read)    chk("start_width", prev_start, 0);
            if (spi_continue_read) chk("cont_width", prev_cont, 0);
            if (spi_stop_read)     chk("stop_width", prev_stop, 0);
            prev_start = spi_start_read;
            prev_cont  = spi_continue_read;
            prev_stop  = spi_stop_read;
        end
    end

    initial begin : main
        int n;
        int t0;
        int s0;
        int s1;
        int c1;
        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_sample", sample, 8'h80);
        chk("rst_strobe", sample_strobe, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_ucnt", underrun_count, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_spi", {spi_start_read, spi_continue_read, spi_stop_read}, 3'b000);
        chk("spi_addr", spi_addr, 24'h000000);
        rst = 1'b0;
        @(negedge clk);
        #2;
        enable = 1'b1;
        @(negedge clk);
        #2;
        chk("start_latency", spi_start_read, 1);

        // First wrap of the 6-byte region happens during the initial fill.
        n = 0;
        while (!spi_stop_read && n < 100) begin @(negedge clk); #2; n++; end
        chk("wrap_stop_seen", spi_stop_read, 1);
        @(negedge clk);
        #2;
        chk("wrap_start_next", spi_start_read, 1);
        chk("wrap_stops", stops, 1);
        chk("wrap_starts", starts, 2);

        n = 0;
        while (fifo_level != 4'd8 && n < 100) begin @(negedge clk); #2; n++; end
        chk("fill_level", fifo_level, 8);
        chk("fill_starts", starts, 2);
        chk("fill_conts", conts, 6);
        repeat (10) @(negedge clk);
        #2;
        chk("fill_paused", conts, 6);

        n = 0;
        while (!sample_strobe && n < 200) begin @(negedge clk); #2; n++; end
        chk("strobe_seen", sample_strobe, 1);
        t0 = cyc;
        @(negedge clk);
        #2;
        n = 0;
        while (!sample_strobe && n < 200) begin @(negedge clk); #2; n++; end
        chk("strobe_period", cyc - t0, DIV);
        repeat (DIV * 16) @(negedge clk);

        // Stall mid-stream: FIFO drains, underruns are scored by the monitor.
        #2;
        stall_len = 2000;
        repeat (2000 + DIV * 16) @(negedge clk);
        #2;
        chk("stall_underruns", underrun_count != 8'h00, 1);

        stall_len = 18000;
        repeat (18000 + DIV * 10) @(negedge clk);
        #2;
        chk("ucnt_saturated", underrun_count, 8'hFF);
        n = 0;
        while (!sample_strobe && n < 2 * DIV) begin @(negedge clk); #2; n++; end
        chk("resume_strobe", sample_strobe, 1);

        // Drop enable while a read sits in WAIT_LO.
        stall_len = 10;
        n = 0;
        while (!spi_busy && n < 200) begin @(negedge clk); #2; n++; end
        chk("busy_seen", spi_busy, 1);
        @(negedge clk);
        #2;
        s0     = stops;
        s1     = starts;
        c1     = conts;
        enable = 1'b0;
        repeat (30) @(negedge clk);
        #2;
        chk("drop_one_stop", stops, s0 + 1);
        chk("drop_no_reads", starts + conts, s1 + c1);
        chk("drop_level", fifo_level, 0);
        chk("drop_sample", sample, 8'h80);
        chk("drop_ucnt_kept", underrun_count, 8'hFF);
        chk("drop_busy_done", spi_busy, 0);
        enable = 1'b1;
        @(negedge clk);
        #2;
        chk("reenable_start", spi_start_read, 1);
        n = 0;
        while (!sample_strobe && n < 2 * DIV) begin @(negedge clk); #2; n++; end
        chk("reenable_first", {sample_strobe, sample}, {1'b1, 8'h00});

        // Reset in the middle of a read.
        n = 0;
        while (!spi_busy && n < 200) begin @(negedge clk); #2; n++; end
        chk("busy_seen2", spi_busy, 1);
        s0  = stops;
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("rst_mid_sample", sample, 8'h80);
        chk("rst_mid_flags", {sample_strobe, underrun}, 2'b00);
        chk("rst_mid_ucnt", underrun_count, 0);
        chk("rst_mid_level", fifo_level, 0);
        chk("rst_mid_spi", {spi_start_read, spi_continue_read, spi_stop_read}, 3'b000);
        repeat (4) @(negedge clk);
        #2;
        chk("rst_no_stop", stops, s0);
        rst = 1'b0;
        repeat (DIV * 4) @(negedge clk);
        #2;
        chk("post_rst_ucnt", underrun_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
